// File: rtl/vx_issue_pkg.sv
// Shared definitions for the warp issue arbiter: execution-unit codes and the
// issue request record handed to dispatch.
package vx_issue_pkg;

  localparam int ISSUE_NUM_WARPS = 4;
  localparam int ISSUE_EX_BITS   = 3;
  localparam int ISSUE_DATAW     = 128;
  localparam int ISSUE_WB        = $clog2(ISSUE_NUM_WARPS);

  localparam int EX_NOP      = 0;
  localparam int EX_ALU      = 1;
  localparam int EX_BITMANIP = 2;
  localparam int EX_LSU      = 3;
  localparam int EX_CSR      = 4;
  localparam int EX_FPU      = 5;
  localparam int EX_GPU      = 6;

  typedef struct packed {
    logic [ISSUE_WB-1:0]      wid;
    logic [ISSUE_EX_BITS-1:0] ex_type;
    logic [ISSUE_DATAW-1:0]   data;
  } issue_req_t;

endpackage

// File: rtl/vx_rr_find_first.sv
// Rotating priority encoder: reports the first set request bit found when
// searching from start_i upward, wrapping at N.
module vx_rr_find_first #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = int'(start_i) + i;
      if (pos >= N) pos = pos - N;
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = W'(pos);
      end
    end
  end

endmodule

// File: rtl/vx_issue_arbiter.sv
// Per-core warp issue arbiter: round-robin over ready warps with a starvation
// override, feeding a one-entry registered request stage into dispatch.
module vx_issue_arbiter
  import vx_issue_pkg::*;
#(
  parameter  int NUM_WARPS    = 4,
  parameter  int EX_BITS      = 3,
  parameter  int NUM_EX       = 6,
  parameter  int DATAW        = 128,
  parameter  int STARVE_LIMIT = 15,
  localparam int WB           = $clog2(NUM_WARPS),
  localparam int SB           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_WARPS-1:0]         in_valid,
  input  logic [NUM_WARPS*EX_BITS-1:0] in_ex_type,
  input  logic [NUM_WARPS*DATAW-1:0]   in_data,
  output logic [NUM_WARPS-1:0]         in_ready,
  input  logic [NUM_EX-1:0]            unit_ready,
  output logic                         out_valid,
  output logic [WB-1:0]                out_wid,
  output logic [EX_BITS-1:0]           out_ex_type,
  output logic [DATAW-1:0]             out_data,
  input  logic                         out_ready
);

  typedef struct packed {
    logic [WB-1:0]      wid;
    logic [EX_BITS-1:0] ex_type;
    logic [DATAW-1:0]   data;
  } req_t;

  logic                         outValid_q, outValid_d;
  req_t                         outReq_q, outReq_d;
  logic [WB-1:0]                rrPtr_q, rrPtr_d;
  logic [NUM_WARPS-1:0][SB-1:0] cnt_q, cnt_d;

  logic [NUM_WARPS-1:0] elig, starve;
  logic [EX_BITS-1:0]   exType;
  logic                 unitOk;
  logic                 free, rrFound, starveFound, grantValid;
  logic [WB-1:0]        rrIdx, starveIdx, grantIdx;

  assign free = !outValid_q || out_ready;

  // NOP and codes beyond the last unit bypass the ready hint entirely.
  always_comb begin
    elig   = '0;
    starve = '0;
    exType = '0;
    unitOk = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      exType = in_ex_type[w*EX_BITS +: EX_BITS];
      unitOk = 1'b0;
      for (int k = 0; k < NUM_EX; k++) begin
        if (int'(exType) == k + 1) unitOk = unit_ready[k];
      end
      elig[w]   = in_valid[w] && (int'(exType) == EX_NOP || int'(exType) > NUM_EX || unitOk);
      starve[w] = in_valid[w] && (cnt_q[w] == SB'(STARVE_LIMIT));
    end
  end

  vx_rr_find_first #(.N(NUM_WARPS)) rrFind (
    .req_i   (elig),
    .start_i (rrPtr_q),
    .found_o (rrFound),
    .idx_o   (rrIdx)
  );

  vx_rr_find_first #(.N(NUM_WARPS)) starveFind (
    .req_i   (starve),
    .start_i ('0),
    .found_o (starveFound),
    .idx_o   (starveIdx)
  );

  // Gating with reset_n keeps the pop strobe quiet while reset is held.
  assign grantValid = reset_n && free && (starveFound || rrFound);
  assign grantIdx   = starveFound ? starveIdx : rrIdx;

  always_comb begin
    in_ready = '0;
    if (grantValid) in_ready[grantIdx] = 1'b1;
  end

  always_comb begin
    outValid_d = outValid_q;
    outReq_d   = outReq_q;
    rrPtr_d    = rrPtr_q;
    if (grantValid) begin
      outValid_d       = 1'b1;
      outReq_d.wid     = grantIdx;
      outReq_d.ex_type = in_ex_type[int'(grantIdx)*EX_BITS +: EX_BITS];
      outReq_d.data    = in_data[int'(grantIdx)*DATAW +: DATAW];
      rrPtr_d          = (int'(grantIdx) == NUM_WARPS - 1) ? '0 : grantIdx + 1'b1;
    end else if (free) begin
      outValid_d = 1'b0;
    end
  end

  // A stalled output stage counts as a lost cycle for every waiting warp.
  always_comb begin
    cnt_d = cnt_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (!in_valid[w] || (grantValid && int'(grantIdx) == w)) begin
        cnt_d[w] = '0;
      end else if (cnt_q[w] != SB'(STARVE_LIMIT)) begin
        cnt_d[w] = cnt_q[w] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid_q <= 1'b0;
      outReq_q   <= '0;
      rrPtr_q    <= '0;
      cnt_q      <= '0;
    end else begin
      outValid_q <= outValid_d;
      outReq_q   <= outReq_d;
      rrPtr_q    <= rrPtr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_wid     = outReq_q.wid;
  assign out_ex_type = outReq_q.ex_type;
  assign out_data    = outReq_q.data;

endmodule

// File: tb/tb_vx_issue_arbiter.sv
// Directed bench for vx_issue_arbiter: rotation, unit-ready skip, backpressure,
// starvation override, asynchronous reset, NOP/out-of-range codes and idle.
module tb_vx_issue_arbiter;

  localparam int NW  = 4;
  localparam int EXB = 3;
  localparam int NEX = 6;
  localparam int DW  = 128;
  localparam int SL  = 15;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NW-1:0]     in_valid;
  logic [NW*EXB-1:0] in_ex_type;
  logic [NW*DW-1:0]  in_data;
  logic [NW-1:0]     in_ready;
  logic [NEX-1:0]    unit_ready;
  logic              out_valid;
  logic [1:0]        out_wid;
  logic [EXB-1:0]    out_ex_type;
  logic [DW-1:0]     out_data;
  logic              out_ready;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  vx_issue_arbiter #(
    .NUM_WARPS(NW), .EX_BITS(EXB), .NUM_EX(NEX), .DATAW(DW), .STARVE_LIMIT(SL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ex_type  (in_ex_type),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .unit_ready  (unit_ready),
    .out_valid   (out_valid),
    .out_wid     (out_wid),
    .out_ex_type (out_ex_type),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  function automatic logic [DW-1:0] dataOf(input int w);
    return {4{32'hC0DE_0000 + 32'(w)}};
  endfunction

  function automatic logic [NW*EXB-1:0] exPack(input int e0, input int e1, input int e2, input int e3);
    return {EXB'(e3), EXB'(e2), EXB'(e1), EXB'(e0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NW-1:0] valid, input logic [NW*EXB-1:0] exTypes,
                               input logic [NEX-1:0] unitReady, input logic outReady);
    in_valid   = valid;
    in_ex_type = exTypes;
    unit_ready = unitReady;
    out_ready  = outReady;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectOut(input string tag, input logic valid, input int wid, input int exType);
    checkOutput({tag, "_valid"}, DW'(out_valid), DW'(valid));
    if (valid) begin
      checkOutput({tag, "_wid"}, DW'(out_wid), DW'(wid));
      checkOutput({tag, "_ex"}, DW'(out_ex_type), DW'(exType));
      checkOutput({tag, "_data"}, out_data, dataOf(wid));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pat [3];
    logic [NW*EXB-1:0] allAlu;
    pat    = '{0, 1, 3};
    allAlu = exPack(1, 1, 1, 1);
    for (int w = 0; w < NW; w++) in_data[w*DW +: DW] = dataOf(w);

    reset_n = 1'b0;
    applyStimulus(4'hF, allAlu, 6'h3F, 1'b1);
    repeat (2) nextCycle();
    checkOutput("reset_in_ready", DW'(in_ready), '0);
    checkOutput("reset_valid", DW'(out_valid), '0);
    checkOutput("reset_wid", DW'(out_wid), '0);
    checkOutput("reset_ex", DW'(out_ex_type), '0);
    checkOutput("reset_data", out_data, '0);

    // Full contention: strict rotation with no bubbles.
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("rot_grant", DW'(in_ready), DW'(4'b0001 << (i % 4)));
      nextCycle();
      expectOut("rot_out", 1'b1, i % 4, 1);
    end
    applyStimulus(4'h0, allAlu, 6'h3F, 1'b1);
    checkOutput("idle_grant", DW'(in_ready), '0);
    nextCycle();
    expectOut("idle_out", 1'b0, 0, 0);

    // Steer the pointer back to 0, then skip warp 0 while its LSU is busy.
    applyStimulus(4'b1000, allAlu, 6'h3F, 1'b1);
    checkOutput("w3_grant", DW'(in_ready), 4'b1000);
    nextCycle();
    expectOut("w3_out", 1'b1, 3, 1);
    applyStimulus(4'b0011, exPack(3, 1, 1, 1), 6'b111011, 1'b1);
    checkOutput("skip_grant", DW'(in_ready), 4'b0010);
    nextCycle();
    expectOut("skip_out", 1'b1, 1, 1);
    applyStimulus(4'b0001, exPack(3, 1, 1, 1), 6'b111011, 1'b1);
    checkOutput("busy_grant", DW'(in_ready), '0);
    nextCycle();
    expectOut("busy_out", 1'b0, 0, 0);
    applyStimulus(4'b0001, exPack(3, 1, 1, 1), 6'h3F, 1'b1);
    checkOutput("lsu_grant", DW'(in_ready), 4'b0001);
    nextCycle();
    expectOut("lsu_out", 1'b1, 0, 3);
    applyStimulus(4'h0, allAlu, 6'h3F, 1'b1);
    nextCycle();

    // Backpressure with warp 2 held in the output stage.
    applyStimulus(4'hF, allAlu, 6'h3F, 1'b1);
    checkOutput("bp_grant1", DW'(in_ready), 4'b0010);
    nextCycle();
    expectOut("bp_out1", 1'b1, 1, 1);
    checkOutput("bp_grant2", DW'(in_ready), 4'b0100);
    nextCycle();
    expectOut("bp_out2", 1'b1, 2, 1);
    applyStimulus(4'hF, allAlu, 6'h3F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_stall_grant", DW'(in_ready), '0);
      nextCycle();
      expectOut("bp_stall_out", 1'b1, 2, 1);
    end
    applyStimulus(4'hF, allAlu, 6'h3F, 1'b1);
    checkOutput("bp_release_grant", DW'(in_ready), 4'b1000);
    nextCycle();
    expectOut("bp_release_out", 1'b1, 3, 1);
    applyStimulus(4'h0, allAlu, 6'h3F, 1'b1);
    nextCycle();
    expectOut("bp_idle_out", 1'b0, 0, 0);

    // Warp 2 waits on a busy CSR unit until its counter saturates.
    applyStimulus(4'hF, exPack(1, 1, 4, 1), 6'b110111, 1'b1);
    for (int i = 0; i < SL; i++) begin
      checkOutput("starve_rr_grant", DW'(in_ready), DW'(4'b0001 << pat[i % 3]));
      nextCycle();
      expectOut("starve_rr_out", 1'b1, pat[i % 3], 1);
    end
    checkOutput("starve_force_grant", DW'(in_ready), 4'b0100);
    nextCycle();
    expectOut("starve_force_out", 1'b1, 2, 4);
    checkOutput("starve_after_grant", DW'(in_ready), 4'b1000);
    nextCycle();
    expectOut("starve_after_out", 1'b1, 3, 1);

    // Asynchronous reset while a request is held.
    reset_n = 1'b0;
    #1;
    checkOutput("areset_valid", DW'(out_valid), '0);
    checkOutput("areset_wid", DW'(out_wid), '0);
    checkOutput("areset_in_ready", DW'(in_ready), '0);
    #3;
    reset_n = 1'b1;
    applyStimulus(4'hF, allAlu, 6'h3F, 1'b1);
    checkOutput("post_reset_grant", DW'(in_ready), 4'b0001);
    nextCycle();
    expectOut("post_reset_out", 1'b1, 0, 1);

    // Out-of-range and NOP codes ignore unit readiness.
    applyStimulus(4'b0010, exPack(1, 7, 1, 1), 6'h00, 1'b1);
    checkOutput("oor_grant", DW'(in_ready), 4'b0010);
    nextCycle();
    expectOut("oor_out", 1'b1, 1, 7);
    applyStimulus(4'b1000, exPack(1, 1, 1, 0), 6'h00, 1'b1);
    checkOutput("nop_grant", DW'(in_ready), 4'b1000);
    nextCycle();
    expectOut("nop_out", 1'b1, 3, 0);
    applyStimulus(4'h0, allAlu, 6'h3F, 1'b1);
    checkOutput("drain_grant", DW'(in_ready), '0);
    nextCycle();
    expectOut("drain_out", 1'b0, 0, 0);
    applyStimulus(4'hF, allAlu, 6'h3F, 1'b1);
    checkOutput("wrap_grant", DW'(in_ready), 4'b0001);
    nextCycle();
    expectOut("wrap_out", 1'b1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
